// File: rtl/fp32_adder.sv
// fp32_adder: IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero in and out.
// Latency: one clock (combinational datapath into an output register); one op per cycle.
// Backpressure: none; every in_valid pair produces a result on the next cycle.
// Ports: clk, rst_n (sync, active-low), in_valid/op1/op2 in, out_valid/result out.
module fp32_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        out_valid,
  output logic [31:0] result
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = op1[31];
  assign ea = op1[30:23];
  assign fa = op1[22:0];
  assign sb = op2[31];
  assign eb = op2[30:23];
  assign fb = op2[22:0];

  assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
  // Subnormals are treated as zero on input.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  logic               swap;
  logic               sl, ss;
  logic [7:0]         el, es, d;
  logic [22:0]        fl, fs;
  logic [49:0]        sh_full;
  logic [26:0]        lx, sx;     // {significand[23:0], guard, round, sticky}
  logic [27:0]        sum;
  logic [26:0]        diff, m;
  logic [4:0]         lz;
  logic               found;
  logic signed [9:0]  e;
  logic               rinc;
  logic [24:0]        rsig;
  logic [22:0]        frac_o;
  logic               cancel;
  logic [31:0]        sum_c;

  always_comb begin
    swap = {eb, fb} > {ea, fa};
    sl   = swap ? sb : sa;
    el   = swap ? eb : ea;
    fl   = swap ? fb : fa;
    ss   = swap ? sa : sb;
    es   = swap ? ea : eb;
    fs   = swap ? fa : fb;

    // Align: the bottom 24 bits of the 50-bit window are everything below the round bit.
    d       = el - es;
    sh_full = {1'b1, fs, 26'd0} >> d;
    if (d >= 8'd26)
      sx = 27'd1;
    else
      sx = {sh_full[49:24], |sh_full[23:0]};
    lx = {1'b1, fl, 3'b000};

    sum    = '0;
    diff   = '0;
    m      = '0;
    lz     = '0;
    found  = 1'b0;
    cancel = 1'b0;
    e      = $signed({2'b00, el});

    if (sl == ss) begin
      sum = {1'b0, lx} + {1'b0, sx};
      if (sum[27]) begin
        m = {sum[27:2], |sum[1:0]};
        e = e + 10'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      diff   = lx - sx;
      cancel = (diff == 27'd0);
      for (int i = 26; i >= 0; i--) begin
        if (!found && diff[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      m = diff << lz;
      e = e - $signed({5'b00000, lz});
    end

    rinc = m[2] & (m[1] | m[0] | m[3]);
    rsig = {1'b0, m[26:3]} + {24'd0, rinc};
    // Rounding carry out of the significand leaves 1.000..0; renormalise.
    if (rsig[24]) begin
      frac_o = rsig[23:1];
      e      = e + 10'sd1;
    end else begin
      frac_o = rsig[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      sum_c = 32'h7fc0_0000;
    else if (a_inf)
      sum_c = op1;
    else if (b_inf)
      sum_c = op2;
    else if (a_zero && b_zero)
      sum_c = {sa & sb, 31'd0};
    else if (a_zero)
      sum_c = op2;
    else if (b_zero)
      sum_c = op1;
    else if (cancel)
      sum_c = 32'h0000_0000;
    else if (e >= 10'sd255)
      sum_c = {sl, 8'hff, 23'd0};
    else if (e <= 10'sd0)
      sum_c = {sl, 31'd0};
    else
      sum_c = {sl, e[7:0], frac_o};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        result <= sum_c;
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// tb_fp32_adder: scoreboard bench for fp32_adder against an exact-integer reference sum.
// Latency: expects each valid pair's sum one cycle later, back-to-back.
// Backpressure: none; idle gaps are inserted randomly to exercise out_valid/hold.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] op1, op2;
  logic        out_valid;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expq[$];
  logic [31:0] last_want;

  fp32_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op1      (op1),
    .op2      (op2),
    .out_valid(out_valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference: each operand is an exact integer multiple of 2^-149; sum exactly, then round.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, mag, keep, rem, half, one;
    logic s;
    int p, e, sh;
    logic za, zb;
    one = 300'd1;
    za  = (a[30:23] == 8'd0);
    zb  = (b[30:23] == 8'd0);
    if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0))
      return 32'h7fc0_0000;
    if (a[30:23] == 8'hff && b[30:23] == 8'hff)
      return (a[31] != b[31]) ? 32'h7fc0_0000 : a;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (za && zb) return {a[31] & b[31], 31'd0};
    if (za) return b;
    if (zb) return a;
    ma = 300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
    mb = 300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
    if (a[31] == b[31]) begin
      mag = ma + mb; s = a[31];
    end else if (ma > mb) begin
      mag = ma - mb; s = a[31];
    end else if (mb > ma) begin
      mag = mb - ma; s = b[31];
    end else begin
      return 32'h0000_0000;
    end
    p = -1;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return {s, 31'd0};
    e    = p - 22;
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag & ((one << sh) - one);
    if (sh > 0) begin
      half = one << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + one;
    end
    if (keep == (one << 24)) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] near);
    logic [31:0] specials [8];
    int r, ex;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7f80_0000, 32'hff80_0000,
                 32'h7fc0_0001, 32'h0001_2345, 32'h7f7f_ffff, 32'h0080_0000};
    r = $urandom_range(0, 99);
    if (r < 6)
      return specials[$urandom_range(0, 7)];
    if (r < 16)
      return near ^ 32'h8000_0000 ^ 32'($urandom_range(0, 7));
    if (r < 70) begin
      ex = int'(near[30:23]) + int'($urandom_range(0, 60)) - 30;
      if (ex < 1) ex = 1;
      if (ex > 254) ex = 254;
      return {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
    end
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    @(negedge clk);
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    expq.push_back(want);
    last_want = want;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per presented result.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          check("sum", result, expq.pop_front());
        end
      end
    end
  end

  logic [31:0] dir_a [9];
  logic [31:0] dir_b [9];
  logic [31:0] dir_r [9];

  initial begin
    logic [31:0] a, b, prev;
    dir_a = '{32'h3fa66666, 32'h3f400000, 32'h4083d70a, 32'h410b851f, 32'h42f60000,
              32'h40400000, 32'h3f800000, 32'h7f800000, 32'h7f7fffff};
    dir_b = '{32'h3f99999a, 32'h40500000, 32'h4069999a, 32'h404f5c29, 32'h40a6b852,
              32'hbf800000, 32'hbf800000, 32'hff800000, 32'h7f7fffff};
    dir_r = '{32'h40200000, 32'h40800000, 32'h40f8a3d7, 32'h413f5c29, 32'h430035c3,
              32'h40000000, 32'h00000000, 32'h7fc00000, 32'h7f800000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors, back to back.
    for (int i = 0; i < 9; i++) send(dir_a[i], dir_b[i], dir_r[i]);

    // Dropping in_valid clears out_valid and holds the last result.
    send(32'h3f800000, 32'h40000000, 32'h40400000);
    idle();
    @(negedge clk);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_hold", result, last_want);

    // Randomised traffic with occasional gaps.
    prev = 32'h3f800000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle();
      end else begin
        a = rand_op(prev);
        b = rand_op(a);
        send(a, b, ref_add(a, b));
        prev = b;
      end
    end

    // Reset wins over a valid pair presented in the same cycle.
    send(32'h3f800000, 32'h40000000, 32'h40400000);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    op1 = 32'h40000000;
    op2 = 32'h40000000;
    @(negedge clk);
    check("rst_vld_result", result, 32'h0);
    check("rst_vld_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;

    send(32'h40000000, 32'hc0400000, 32'hbf800000);
    send(32'h80000000, 32'h80000000, 32'h80000000);
    send(32'h80000000, 32'h00000000, 32'h00000000);
    send(32'h00000000, 32'hc1234567, 32'hc1234567);
    repeat (3) idle();
    check("drain", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
